// File: rtl/spi_word_controller_if.sv
// Word-level SPI controller bus: host handshake, received word and the SPI pins.
interface spi_word_controller_if #(
    parameter int BITS = 64
);
    logic            start;
    logic [BITS-1:0] tx_word;
    logic            busy;
    logic            done;
    logic [BITS-1:0] rx_word;
    logic            SCK;
    logic            CS;
    logic            COPI;
    logic            CIPO;

    modport master (
        output start, tx_word, CIPO,
        input  busy, done, rx_word, SCK, CS, COPI
    );

    modport slave (
        input  start, tx_word, CIPO,
        output busy, done, rx_word, SCK, CS, COPI
    );
endinterface

// File: rtl/spi_word_controller.sv
// Mode-0 SPI controller moving one BITS-wide word per CS window, bytes
// little-endian and bits MSB first; CIPO is resynchronised before sampling.
module spi_word_controller #(
    parameter int BITS   = 64,
    parameter int CLKDIV = 4
) (
    input logic                  clk,
    input logic                  resetn,
    spi_word_controller_if.slave bus
);
    localparam int BW = $clog2(BITS);
    localparam int CW = $clog2(CLKDIV);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [BITS-1:0] tx_q, tx_d;
    logic [BITS-1:0] rx_shift_q, rx_shift_d;
    logic [BITS-1:0] rx_word_q, rx_word_d;
    logic            cs_q, cs_d;
    logic            sck_q, sck_d;
    logic            copi_q, copi_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            cipo_meta_q, cipo_sync_q;
    logic            last_tick;

    // Serial bit b lives at word index 8*(b/8) + 7 - (b%8).
    function automatic logic [BW-1:0] wire_order(input logic [BW-1:0] b);
        return {b[BW-1:3], ~b[2:0]};
    endfunction

    assign last_tick = (cnt_q == CW'(CLKDIV - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_shift_q  <= '0;
            rx_word_q   <= '0;
            cs_q        <= 1'b1;
            sck_q       <= 1'b0;
            copi_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cipo_meta_q <= 1'b0;
            cipo_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            rx_shift_q  <= rx_shift_d;
            rx_word_q   <= rx_word_d;
            cs_q        <= cs_d;
            sck_q       <= sck_d;
            copi_q      <= copi_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cipo_meta_q <= bus.CIPO;
            cipo_sync_q <= cipo_meta_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = (state_q == IDLE || last_tick) ? '0 : cnt_q + 1'b1;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_shift_d = rx_shift_q;
        rx_word_d  = rx_word_q;
        cs_d       = cs_q;
        sck_d      = sck_q;
        copi_d     = copi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SETUP;
                    tx_d    = bus.tx_word;
                    bit_d   = '0;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    copi_d  = bus.tx_word[7];
                end
            end
            SETUP, LOW: begin
                if (last_tick) begin
                    state_d = HIGH;
                    sck_d   = 1'b1;
                end
            end
            HIGH: begin
                if (last_tick) begin
                    sck_d                         = 1'b0;
                    rx_shift_d[wire_order(bit_q)] = cipo_sync_q;
                    bit_d                         = bit_q + 1'b1;
                    // The last bit keeps COPI steady through HOLD.
                    if (bit_q == BW'(BITS - 1)) begin
                        state_d = HOLD;
                    end else begin
                        state_d = LOW;
                        copi_d  = tx_q[wire_order(bit_q + 1'b1)];
                    end
                end
            end
            HOLD: begin
                if (last_tick) begin
                    state_d   = GAP;
                    cs_d      = 1'b1;
                    copi_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_word_d = rx_shift_q;
                end
            end
            GAP: begin
                if (last_tick) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_word = rx_word_q;
    assign bus.SCK     = sck_q;
    assign bus.CS      = cs_q;
    assign bus.COPI    = copi_q;
endmodule
